// File: rtl/fp_add_seq.sv
// fp_add_seq: same-sign single-precision adder sequencer.
//
// Unpacks two IEEE-754 operands and aligns the smaller mantissa. It then
// drives one REQ/ACK handshake to an external 24-bit mantissa adder,
// normalizes the captured sum and repacks it.
//
// Ports:
//   CLK, RSTN            clock (rising edge), async active-low reset
//   START, OPA, OPB      start pulse and operands, sampled in IDLE only
//   BUSY, DONE           not-idle flag, one-cycle completion pulse
//   RESULT, OVF, ERR     packed result and flags, held until the next op
//   ADD_REQ, ADD_A/B     adder request and operands (stable while REQ=1)
//   ADD_Z, ADD_COUT      adder sum/carry, valid only while ADD_ACK=1
//   ADD_ACK              adder acknowledge (may be combinational on REQ)
//
// Optional feature macro: FPU_ADD_RNE_EN adds round-to-nearest-even. It
// uses a second adder handshake (ROUND_REQ) when an increment is needed.
// With the macro undefined, results are truncated.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for START
// S_ALIGN    | unpack, special-case check, align smaller mantissa
// S_REQ_WAIT | ADD_REQ high, waiting for ADD_ACK or timeout
// S_NORM     | normalize captured sum, pack result (or request rounding)
// S_ROUND_REQ| (RNE only) increment handshake, ADD_A=mantissa, ADD_B=1
// S_DONE     | DONE pulse, result/flags valid

module fp_add_seq #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [31:0] OPA,
  input  logic [31:0] OPB,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        OVF,
  output logic        ERR,
  output logic        ADD_REQ,
  output logic [23:0] ADD_A,
  output logic [23:0] ADD_B,
  input  logic [23:0] ADD_Z,
  input  logic        ADD_COUT,
  input  logic        ADD_ACK
);

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  TMR_LOAD = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_REQ_WAIT,
    S_NORM,
`ifdef FPU_ADD_RNE_EN
    S_ROUND_REQ,
`endif
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0] opa_q, opb_q;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [23:0] z_q;
  logic        cout_q;
  logic [7:0]  tmr;
  logic        tmr_tc;

  logic [7:0]  exp_a, exp_b, exp_big, exp_diff;
  logic [23:0] man_a, man_b, man_big, man_small, man_shift;
  logic        a_big, special;

  logic [22:0] norm_frac;
  logic [7:0]  norm_exp;
  logic        norm_ovf, norm_zero;
  logic [31:0] norm_res;

`ifdef FPU_ADD_RNE_EN
  logic [47:0] align_ext;
  logic        grd_in, stk_in;
  logic        grd_q, stk_q, rnd_done_q;
  logic        rnd_grd, rnd_stk, need_rnd;
`endif

  assign tmr_tc = (tmr == 8'h00);

  // Unpack and align; only meaningful while in S_ALIGN.
  always_comb begin
    exp_a     = opa_q[30:23];
    exp_b     = opb_q[30:23];
    man_a     = (exp_a != 8'h00) ? {1'b1, opa_q[22:0]} : 24'h0;
    man_b     = (exp_b != 8'h00) ? {1'b1, opb_q[22:0]} : 24'h0;
    special   = (exp_a == 8'hFF) || (exp_b == 8'hFF) || (opa_q[31] != opb_q[31]);
    a_big     = (exp_a >= exp_b);
    exp_big   = a_big ? exp_a : exp_b;
    exp_diff  = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    man_big   = a_big ? man_a : man_b;
    man_small = a_big ? man_b : man_a;
`ifdef FPU_ADD_RNE_EN
    // Low half of the extended shift holds the bits shifted out.
    align_ext = {man_small, 24'h0} >> exp_diff;
    man_shift = (exp_diff >= 8'd24) ? 24'h0 : align_ext[47:24];
    if (exp_diff >= 8'd25) begin
      grd_in = 1'b0;
      stk_in = |man_small;
    end else begin
      grd_in = align_ext[23];
      stk_in = |align_ext[22:0];
    end
`else
    man_shift = (exp_diff >= 8'd24) ? 24'h0 : (man_small >> exp_diff);
`endif
  end

  // Normalize the captured sum. The leading 1 is implied, so only the
  // 23 fraction bits are carried around.
  always_comb begin
    norm_frac = cout_q ? z_q[23:1] : z_q[22:0];
    norm_exp  = exp_q + {7'h00, cout_q};
    norm_ovf  = (norm_exp == 8'hFF);
    norm_zero = (z_q == 24'h0) && !cout_q;
    if (norm_ovf)
      norm_res = {sign_q, 8'hFF, 23'h0};
    else if (norm_zero)
      norm_res = {sign_q, 31'h0};
    else
      norm_res = {sign_q, norm_exp, norm_frac};
`ifdef FPU_ADD_RNE_EN
    rnd_grd  = cout_q ? z_q[0] : grd_q;
    rnd_stk  = cout_q ? (grd_q | stk_q) : stk_q;
    need_rnd = !rnd_done_q && !norm_ovf && !norm_zero &&
               rnd_grd && (rnd_stk || norm_frac[0]);
`endif
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = (state != S_IDLE);
    DONE      = 1'b0;
    case (state)
      S_IDLE:  if (START) state_nxt = S_ALIGN;
      S_ALIGN: state_nxt = special ? S_DONE : S_REQ_WAIT;
      S_REQ_WAIT: begin
        if (ADD_ACK)     state_nxt = S_NORM;
        else if (tmr_tc) state_nxt = S_DONE;
      end
      S_NORM: begin
`ifdef FPU_ADD_RNE_EN
        if (need_rnd) state_nxt = S_ROUND_REQ;
        else          state_nxt = S_DONE;
`else
        state_nxt = S_DONE;
`endif
      end
`ifdef FPU_ADD_RNE_EN
      S_ROUND_REQ: begin
        if (ADD_ACK)     state_nxt = S_NORM;
        else if (tmr_tc) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      opa_q   <= 32'h0;
      opb_q   <= 32'h0;
      sign_q  <= 1'b0;
      exp_q   <= 8'h0;
      z_q     <= 24'h0;
      cout_q  <= 1'b0;
      tmr     <= 8'h0;
      ADD_REQ <= 1'b0;
      ADD_A   <= 24'h0;
      ADD_B   <= 24'h0;
      RESULT  <= 32'h0;
      OVF     <= 1'b0;
      ERR     <= 1'b0;
`ifdef FPU_ADD_RNE_EN
      grd_q      <= 1'b0;
      stk_q      <= 1'b0;
      rnd_done_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            opa_q <= OPA;
            opb_q <= OPB;
          end
        end
        S_ALIGN: begin
          if (special) begin
            RESULT <= QNAN;
            OVF    <= 1'b0;
            ERR    <= 1'b1;
          end else begin
            sign_q  <= opa_q[31];
            exp_q   <= exp_big;
            ADD_A   <= man_big;
            ADD_B   <= man_shift;
            ADD_REQ <= 1'b1;
            tmr     <= TMR_LOAD;
`ifdef FPU_ADD_RNE_EN
            grd_q      <= grd_in;
            stk_q      <= stk_in;
            rnd_done_q <= 1'b0;
`endif
          end
        end
`ifdef FPU_ADD_RNE_EN
        S_REQ_WAIT, S_ROUND_REQ: begin
`else
        S_REQ_WAIT: begin
`endif
          if (ADD_ACK) begin
            // REQ drops on the ACK edge so the adder never sees a repeat.
            z_q     <= ADD_Z;
            cout_q  <= ADD_COUT;
            ADD_REQ <= 1'b0;
`ifdef FPU_ADD_RNE_EN
            if (state == S_ROUND_REQ) rnd_done_q <= 1'b1;
`endif
          end else if (tmr_tc) begin
            ADD_REQ <= 1'b0;
            RESULT  <= QNAN;
            OVF     <= 1'b0;
            ERR     <= 1'b1;
          end else begin
            tmr <= tmr - 8'h01;
          end
        end
        S_NORM: begin
`ifdef FPU_ADD_RNE_EN
          if (need_rnd) begin
            exp_q   <= norm_exp;
            ADD_A   <= {1'b1, norm_frac};
            ADD_B   <= 24'h000001;
            ADD_REQ <= 1'b1;
            tmr     <= TMR_LOAD;
          end else begin
            RESULT <= norm_res;
            OVF    <= norm_ovf;
            ERR    <= 1'b0;
          end
`else
          RESULT <= norm_res;
          OVF    <= norm_ovf;
          ERR    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Testbench for fp_add_seq: table-driven operations through a behavioural
// mantissa adder, with a scoreboard queue for RESULT/OVF/ERR and
// hand-written sequences for timeout, mid-request reset, START while busy
// and stray ACK.

module tb_fp_add_seq;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        START = 1'b0;
  logic [31:0] OPA = 32'h0;
  logic [31:0] OPB = 32'h0;
  logic        BUSY, DONE, OVF, ERR, ADD_REQ, ADD_COUT, ADD_ACK;
  logic [31:0] RESULT;
  logic [23:0] ADD_A, ADD_B, ADD_Z;

  fp_add_seq #(.ACK_TIMEOUT(15)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .OPA(OPA), .OPB(OPB),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .OVF(OVF), .ERR(ERR),
    .ADD_REQ(ADD_REQ), .ADD_A(ADD_A), .ADD_B(ADD_B),
    .ADD_Z(ADD_Z), .ADD_COUT(ADD_COUT), .ADD_ACK(ADD_ACK)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural adder ----------------
  logic        ack_en = 1'b1;
  logic        stray = 1'b0;
  int          wait_n = 0;
  int          wait_cnt = 0;
  int          issues = 0;
  int          req_high = 0;
  int          base_issue = 0;
  int          viol = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [23:0] cap_a = 24'h0;
  logic [23:0] cap_b = 24'h0;
  logic [24:0] sum;

  assign sum      = {1'b0, ADD_A} + {1'b0, ADD_B};
  assign ADD_ACK  = (ADD_REQ && ack_en && (wait_cnt >= wait_n)) || stray;
  assign ADD_Z    = ADD_ACK ? sum[23:0] : 24'hA5A5A5;
  assign ADD_COUT = ADD_ACK ? sum[24] : 1'b1;

  always @(posedge CLK) begin
    prev_ack <= ADD_REQ && ADD_ACK;
    prev_req <= ADD_REQ;
    if (prev_ack && ADD_REQ) viol <= viol + 1;
    if (ADD_REQ) begin
      req_high <= req_high + 1;
      if (!prev_req) begin
        issues <= issues + 1;
        if (issues == base_issue) begin
          cap_a <= ADD_A;
          cap_b <= ADD_B;
        end
      end
    end
    if (ADD_REQ && !ADD_ACK) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  initial forever begin
    @(negedge CLK);
    if (RSTN && DONE) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got DONE=1 expected no pending operation");
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", RESULT, mon_e.res);
        chk("ovf", {31'h0, OVF}, {31'h0, mon_e.ovf});
        chk("err", {31'h0, ERR}, {31'h0, mon_e.err});
      end
    end
  end

  typedef struct packed {
    logic [31:0] a, b, res;
    logic        ovf, err;
    logic [7:0]  lat, wn, reqs, hi;
    logic [23:0] xa, xb;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic ovf, input logic err,
                              input int lat, input int wn, input int reqs, input int hi,
                              input logic [23:0] xa, input logic [23:0] xb);
    vec_t v;
    v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.err = err;
    v.lat = 8'(lat); v.wn = 8'(wn); v.reqs = 8'(reqs); v.hi = 8'(hi);
    v.xa = xa; v.xb = xb;
    return v;
  endfunction

  // intr > 0: pulse START with other operands in that cycle of the op.
  task automatic run_op(input vec_t v, input int intr);
    int   cyc;
    int   hi0;
    logic got;
    base_issue = issues;
    hi0        = req_high;
    wait_n     = int'(v.wn);
    @(negedge CLK);
    START = 1'b1;
    OPA   = v.a;
    OPB   = v.b;
    sb_q.push_back('{res: v.res, ovf: v.ovf, err: v.err});
    @(negedge CLK);
    START = 1'b0;
    cyc   = 1;
    got   = 1'b0;
    while (!got && cyc < 60) begin
      if (DONE) got = 1'b1;
      else begin
        if (cyc == intr) begin
          START = 1'b1;
          OPA   = 32'h7F7FFFFF;
          OPB   = 32'h7F7FFFFF;
        end else START = 1'b0;
        @(negedge CLK);
        cyc++;
      end
    end
    START = 1'b0;
    chk("latency", got ? cyc : -1, int'(v.lat));
    chk("req_count", issues - base_issue, int'(v.reqs));
    chk("req_high_cycles", req_high - hi0, int'(v.hi));
    if (v.reqs != 0) begin
      chk("add_a", {8'h0, cap_a}, {8'h0, v.xa});
      chk("add_b", {8'h0, cap_b}, {8'h0, v.xb});
    end
    @(negedge CLK);
    chk("busy_after", {31'h0, BUSY}, 32'h0);
  endtask

  vec_t vecs [0:14];

  initial begin
`ifdef FPU_ADD_RNE_EN
    vecs[12] = mk(32'h3F800003, 32'h3F800000, 32'h40000002, 0, 0, 6, 0, 2, 2, 24'h800003, 24'h800000);
`else
    vecs[12] = mk(32'h3F800003, 32'h3F800000, 32'h40000001, 0, 0, 4, 0, 1, 1, 24'h800003, 24'h800000);
`endif
    vecs[0]  = mk(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 4, 0, 1, 1, 24'h800000, 24'h800000);
    vecs[1]  = mk(32'h3FC00000, 32'h3E800000, 32'h3FE00000, 0, 0, 7, 3, 1, 4, 24'hC00000, 24'h200000);
    vecs[2]  = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0, 4, 0, 1, 1, 24'hFFFFFF, 24'hFFFFFF);
    vecs[3]  = mk(32'h3F800000, 32'hBF800000, 32'h7FC00000, 0, 1, 2, 0, 0, 0, 24'h0, 24'h0);
    vecs[4]  = mk(32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 4, 0, 1, 1, 24'h0, 24'h0);
    vecs[5]  = mk(32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 4, 0, 1, 1, 24'h0, 24'h0);
    vecs[6]  = mk(32'h3F800000, 32'h33800000, 32'h3F800000, 0, 0, 4, 0, 1, 1, 24'h800000, 24'h000000);
    vecs[7]  = mk(32'h7F800000, 32'h3F800000, 32'h7FC00000, 0, 1, 2, 0, 0, 0, 24'h0, 24'h0);
    vecs[8]  = mk(32'h40400000, 32'h3F800000, 32'h40800000, 0, 0, 5, 1, 1, 2, 24'hC00000, 24'h400000);
    vecs[9]  = mk(32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 4, 0, 1, 1, 24'h800000, 24'h400000);
    vecs[10] = mk(32'hBFC00000, 32'hBE800000, 32'hBFE00000, 0, 0, 4, 0, 1, 1, 24'hC00000, 24'h200000);
    vecs[11] = mk(32'h3F800001, 32'h3F800000, 32'h40000000, 0, 0, 4, 0, 1, 1, 24'h800001, 24'h800000);
    vecs[13] = mk(32'h00400000, 32'h3F800000, 32'h3F800000, 0, 0, 4, 0, 1, 1, 24'h800000, 24'h000000);
    vecs[14] = mk(32'h3F800000, 32'hFF800000, 32'h7FC00000, 0, 1, 2, 0, 0, 0, 24'h0, 24'h0);

    // reset values
    #2 RSTN = 1'b0;
    #1;
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_req", {31'h0, ADD_REQ}, 32'h0);
    chk("rst_result", RESULT, 32'h0);
    chk("rst_flags", {30'h0, OVF, ERR}, 32'h0);
    chk("rst_add_ab", {ADD_A[15:0], ADD_B[15:0]}, 32'h0);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("idle_busy", {31'h0, BUSY}, 32'h0);

    for (int i = 0; i < 15; i++) run_op(vecs[i], 0);

    // adder timeout, then a normal op with a live adder
    ack_en = 1'b0;
    run_op(mk(32'h3F800000, 32'h3F800000, 32'h7FC00000, 0, 1, 17, 0, 1, 15, 24'h800000, 24'h800000), 0);
    ack_en = 1'b1;
    run_op(vecs[0], 0);

    // reset while waiting for ACK
    ack_en = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    OPA   = 32'h3F800000;
    OPB   = 32'h3F800000;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("mid_req_high", {31'h0, ADD_REQ}, 32'h1);
    #2 RSTN = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, ADD_REQ}, 32'h0);
    chk("mid_rst_busy", {31'h0, BUSY}, 32'h0);
    repeat (2) @(negedge CLK);
    chk("mid_rst_result", RESULT, 32'h0);
    RSTN   = 1'b1;
    ack_en = 1'b1;
    run_op(vecs[0], 0);

    // START while busy is ignored
    run_op(mk(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 8, 4, 1, 5, 24'h800000, 24'h800000), 2);

    // stray ACK while idle
    stray = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("stray_busy", {31'h0, BUSY}, 32'h0);
    end
    stray = 1'b0;
    chk("held_result", RESULT, 32'h40000000);

    repeat (4) @(negedge CLK);
    chk("sb_empty", sb_q.size(), 0);
    chk("req_after_ack", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_seq.md
# fp_add_seq

Sequencer for same-sign single-precision addition, acting as the initiator of the 24-bit mantissa adder's REQ/ACK handshake. It unpacks two IEEE-754 operands and aligns the smaller mantissa. It then issues one request to the external 24-bit adder, captures Z/COUT, normalizes and repacks the result. It sits between the FPU operand registers and the shared mantissa adder.

## Interface
- ACK_TIMEOUT, 15: maximum cycles ADD_REQ stays high without ADD_ACK before abort (1..255).
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  start pulse; accepted only in IDLE.
- OPA, OPB  in  32  IEEE-754 single operands, sampled on accepted START.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  32  packed result, held until the next accepted START.
- OVF  out  1  exponent overflow on the last operation; held with RESULT.
- ERR  out  1  unsupported operand or adder timeout; held with RESULT.
- ADD_REQ  out  1  request to the adder (registered).
- ADD_A, ADD_B  out  24  adder operands; stable whenever ADD_REQ=1.
- ADD_Z  in  24  adder sum; valid only while ADD_ACK=1.
- ADD_COUT  in  1  adder carry; valid only while ADD_ACK=1.
- ADD_ACK  in  1  adder acknowledge; may be combinational in the REQ cycle.

## Operation
- Reset values: every output is 0, and the state is IDLE.
- Unpack:
  - mantissa = {exp!=0, frac}.
  - An exponent of 0 flushes the operand to zero (exp 0, mantissa 0).
- States: IDLE -> ALIGN -> REQ_WAIT -> NORM -> DONE -> IDLE. With RNE_EN, a ROUND_REQ state follows NORM.
- ALIGN:
  - Special case: if either exponent is 255, or the signs differ, the block goes to DONE with ERR=1 and RESULT=0x7FC00000. No request is issued.
  - Otherwise the larger-exponent operand drives ADD_A. The other mantissa is right-shifted by the exponent difference and drives ADD_B. A difference of 24 or more gives 0.
  - On ties in exponent, OPA drives ADD_A.
- REQ_WAIT:
  - ADD_REQ=1.
  - On the edge where ADD_ACK is sampled 1: capture ADD_Z/ADD_COUT, clear ADD_REQ, go to NORM.
  - ADD_REQ must be low in the cycle after ACK, so the responder never sees a second request.
- Timeout:
  - A counter increments in each REQ_WAIT cycle with ADD_ACK=0.
  - When ADD_REQ has been high ACK_TIMEOUT cycles without ACK: ADD_REQ drops, ERR=1, RESULT=0x7FC00000, go to DONE.
- NORM:
  - If COUT=1: mantissa = {1, Z[23:1]} and exp = exp+1.
  - If the new exp is 255: OVF=1 and RESULT = {sign, 8'hFF, 23'h0}.
  - If Z=0 and COUT=0 (both operands zero): RESULT = {sign, 31'h0}.
  - Otherwise RESULT = {sign, exp, mantissa[22:0]}.
- Rounding without RNE_EN: truncation; shifted-out bits are discarded.
- DONE: DONE=1 for one cycle, then IDLE.
- START while BUSY=1 is ignored.

## Timing
- Cycle 0 is the START-sample edge.
- Zero-wait adder:
  - ALIGN in cycle 1.
  - ADD_REQ and ADD_ACK high in cycle 2.
  - NORM in cycle 3.
  - DONE=1 in cycle 4, with RESULT, OVF and ERR valid in the same cycle.
- Each adder wait cycle adds one cycle.
- Special or ERR bypass: DONE in cycle 2.
- Reset mid-operation: RSTN low clears ADD_REQ, BUSY and state immediately without waiting for a clock. A partial result is never reported.
- ADD_ACK seen outside REQ_WAIT is ignored.

## Configuration
- FPU_ADD_RNE_EN defined:
  - Guard and sticky bits are kept from the alignment shift and from the COUT shift.
  - If rounding is needed (guard and (sticky or lsb)), ROUND_REQ issues a second handshake with ADD_A=mantissa and ADD_B=1.
  - COUT on that increment renormalizes the result (exp+1, with the overflow check).
  - Latency is +2 cycles only when an increment occurs.
- FPU_ADD_RNE_EN undefined: round toward zero, at most one adder request per operation, and no ROUND_REQ state.

## Test plan
- 1.0 + 1.0: 0x3F800000 + 0x3F800000 -> ADD_A = ADD_B = 0x800000, COUT=1, RESULT=0x40000000, DONE in cycle 4.
- 1.5 + 0.25: 0x3FC00000 + 0x3E800000 -> ADD_B=0x200000, RESULT=0x3FE00000, OVF=0, ERR=0.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> OVF=1, RESULT=0x7F800000.
- Sign mismatch: 0x3F800000 + 0xBF800000 -> ADD_REQ never asserted, ERR=1, RESULT=0x7FC00000, DONE in cycle 2.
- Timeout: ADD_ACK tied 0 with ACK_TIMEOUT=15 -> ADD_REQ high exactly 15 cycles, then ERR=1 and DONE. A following START with a live adder completes normally.
- Reset mid-request: RSTN low during REQ_WAIT -> ADD_REQ=0 and BUSY=0 before the next edge, DONE never pulses; after release, START 1.0 + 1.0 gives 0x40000000.
